// File: rtl/add_to_acap_sim_pkg.sv
// Shared parameters, derived sizes and FSM state type for the FHEW accumulator update model.
package add_to_acap_sim_pkg;

  localparam int     RING_DEPTH    = 10;
  localparam int     RING_SIZE     = 1 << RING_DEPTH;
  localparam int     DATA_SIZE_ARB = 32;
  localparam longint Q             = longint'(1) << 27;
  localparam int     PE_NUMBER     = 8;
  localparam int     NTT_NUMBER    = 2;
  localparam int     LWE_SIZE      = 500;
  localparam int     D_R           = 3;
  localparam int     B_R           = 23;
  localparam int     A_WIDTH       = 5;
  localparam int     LOG_BG        = 9;
  localparam int     D_G           = 3;

  function automatic int idx_width(input longint n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int key_words(input int n, input int w, input int d_g);
    return 4 * d_g * n / w;
  endfunction

  localparam int     KEY_WORDS         = key_words(RING_SIZE, PE_NUMBER * NTT_NUMBER, D_G);
  localparam longint SECRET_KEY_SIZE   = longint'(LWE_SIZE * D_R * (B_R - 1)) * KEY_WORDS;
  localparam int     SECRET_ADDR_WIDTH = idx_width(SECRET_KEY_SIZE);

  typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} acap_state_e;

endpackage

// File: rtl/add_to_acap_sim_shift_reg.sv
// SHIFT-stage delay line with asynchronous active-low clear.
module ShiftReg #(
  parameter int SHIFT = 1,
  parameter int DATA  = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [DATA-1:0] data_in,
  output logic [DATA-1:0] data_out
);

  logic [DATA-1:0] stage [SHIFT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SHIFT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data_in;
      for (int i = 1; i < SHIFT; i++) stage[i] <= stage[i-1];
    end
  end

  assign data_out = stage[SHIFT-1];

endmodule

// File: rtl/add_to_acap_sim.sv
// Behavioural FHEW accumulator update ACC <- ACC + ACC (x) BK[k][a_k], streaming
// key words from an external ROM with a fixed two-cycle read latency.
module add_to_acap_sim #(
  parameter int     RING_DEPTH    = add_to_acap_sim_pkg::RING_DEPTH,
  parameter int     DATA_SIZE_ARB = add_to_acap_sim_pkg::DATA_SIZE_ARB,
  parameter longint Q             = add_to_acap_sim_pkg::Q,
  parameter int     PE_NUMBER     = add_to_acap_sim_pkg::PE_NUMBER,
  parameter int     NTT_NUMBER    = add_to_acap_sim_pkg::NTT_NUMBER,
  parameter int     LWE_SIZE      = add_to_acap_sim_pkg::LWE_SIZE,
  parameter int     D_R           = add_to_acap_sim_pkg::D_R,
  parameter int     B_R           = add_to_acap_sim_pkg::B_R,
  parameter int     A_WIDTH       = add_to_acap_sim_pkg::A_WIDTH,
  parameter int     LOG_BG        = add_to_acap_sim_pkg::LOG_BG,
  parameter int     D_G           = add_to_acap_sim_pkg::D_G,
  localparam int     N                 = 1 << RING_DEPTH,
  localparam int     W                 = PE_NUMBER * NTT_NUMBER,
  localparam int     KEY_WORDS         = add_to_acap_sim_pkg::key_words(N, W, D_G),
  localparam int     LWE_D             = LWE_SIZE * D_R,
  localparam int     A_IDX_W           = add_to_acap_sim_pkg::idx_width(LWE_D),
  localparam longint SECRET_KEY_SIZE   = longint'(LWE_D * (B_R - 1)) * KEY_WORDS,
  localparam int     SECRET_ADDR_WIDTH = add_to_acap_sim_pkg::idx_width(SECRET_KEY_SIZE)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         write_enable_bram,
  input  logic [RING_DEPTH:0]          write_addr_input,
  input  logic [DATA_SIZE_ARB-1:0]     data_in,
  input  logic                         load_a,
  input  logic [DATA_SIZE_ARB-1:0]     data_a,
  input  logic [A_IDX_W-1:0]           write_addr_a,
  input  logic                         start_addToACAP,
  input  logic [DATA_SIZE_ARB*W-1:0]   secret_key,
  input  logic [RING_DEPTH:0]          read_out,
  output logic                         done,
  output logic [DATA_SIZE_ARB-1:0]     data_out,
  output logic [SECRET_ADDR_WIDTH-1:0] secret_addr
);

  import add_to_acap_sim_pkg::*;

  // Address register, external ROM register and its address delay stage.
  localparam int     KEY_LATENCY = 3;
  localparam int     WPR         = N / W;
  localparam int     KW_W        = idx_width(KEY_WORDS);
  localparam int     IC_W        = idx_width(KEY_WORDS + 1);
  localparam longint DIGIT_MASK  = (longint'(1) << LOG_BG) - 1;

  acap_state_e state, state_next;

  logic [DATA_SIZE_ARB-1:0] acc     [2][N];
  logic [DATA_SIZE_ARB-1:0] acc_upd [2][N];
  logic [DATA_SIZE_ARB-1:0] key_buf [2*D_G][2][N];
  logic [A_WIDTH-1:0]       a_mem   [LWE_D];

  logic [A_IDX_W-1:0] k;
  logic [IC_W-1:0]    issue_cnt;
  logic [A_WIDTH-1:0] a_val;
  logic               last_k, host_access;
  logic               issue, advance, finish, start_run, compute_en;
  logic [KW_W:0]      tag_in, tag_out;
  logic               cap_valid, last_cap;
  logic [KW_W-1:0]    cap_word;
  int                 key_base, cap_row, cap_col, cap_base;
  logic               unused_bits;

  assign a_val       = a_mem[k];
  assign last_k      = (int'(k) == LWE_D - 1);
  assign host_access = (state == IDLE) || (state == DONE);
  assign key_base    = (int'(k) * (B_R - 1) + int'(a_val) - 1) * KEY_WORDS;
  assign unused_bits = ^data_a[DATA_SIZE_ARB-1:A_WIDTH];

  // Each issued address carries a tag that emerges exactly when its key word lands.
  assign tag_in    = {issue, issue_cnt[KW_W-1:0]};
  assign cap_valid = tag_out[KW_W];
  assign cap_word  = tag_out[KW_W-1:0];
  assign last_cap  = cap_valid && (int'(cap_word) == KEY_WORDS - 1);
  assign cap_row   = int'(cap_word) / (2 * WPR);
  assign cap_col   = (int'(cap_word) / WPR) % 2;
  assign cap_base  = (int'(cap_word) % WPR) * W;

  ShiftReg #(.SHIFT(KEY_LATENCY), .DATA(KW_W + 1)) u_tag_dly (
    .clk      (clk),
    .resetn   (resetn),
    .data_in  (tag_in),
    .data_out (tag_out)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    start_run  = 1'b0;
    compute_en = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start_addToACAP) begin
          start_run  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (a_val == '0) begin
          if (last_k) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            advance = 1'b1;
          end
        end else begin
          issue = (int'(issue_cnt) < KEY_WORDS);
          if (last_cap) state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        compute_en = 1'b1;
        if (last_k) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done        <= 1'b0;
      secret_addr <= '0;
      k           <= '0;
      issue_cnt   <= '0;
    end else begin
      if (start_run) begin
        done      <= 1'b0;
        k         <= '0;
        issue_cnt <= '0;
      end
      if (issue) begin
        secret_addr <= SECRET_ADDR_WIDTH'(key_base + int'(issue_cnt));
        issue_cnt   <= issue_cnt + IC_W'(1);
      end
      if (advance) begin
        k         <= k + A_IDX_W'(1);
        issue_cnt <= '0;
      end
      if (finish) done <= 1'b1;
    end
  end

  // Storage is never cleared; host writes are only honoured between runs.
  always_ff @(posedge clk) begin
    if (write_enable_bram && host_access)
      acc[write_addr_input[RING_DEPTH]][write_addr_input[RING_DEPTH-1:0]] <= data_in;
    if (compute_en) acc <= acc_upd;
    if (load_a && host_access) a_mem[write_addr_a] <= data_a[A_WIDTH-1:0];
    if (cap_valid)
      for (int p = 0; p < W; p++)
        key_buf[cap_row][cap_col][cap_base + p] <= secret_key[p*DATA_SIZE_ARB +: DATA_SIZE_ARB];
  end

  // Gadget-decompose both accumulator halves and multiply negacyclically (X^N = -1).
  always_comb begin : update_blk
    longint sum;
    longint digit;
    acc_upd = acc;
    sum     = 0;
    digit   = 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < N; i++) begin
        sum = 0;
        for (int l = 0; l < 2 * D_G; l++) begin
          for (int j = 0; j < N; j++) begin
            digit = (longint'(acc[l / D_G][j]) >> ((l % D_G) * LOG_BG)) & DIGIT_MASK;
            if (j <= i) sum = sum + digit * longint'(key_buf[l][c][i - j]);
            else        sum = sum - digit * longint'(key_buf[l][c][i - j + N]);
          end
        end
        sum = sum % Q;
        if (sum < 0) sum = sum + Q;
        acc_upd[c][i] = DATA_SIZE_ARB'((longint'(acc[c][i]) + sum) % Q);
      end
    end
  end

  assign data_out = acc[read_out[RING_DEPTH]][read_out[RING_DEPTH-1:0]];

endmodule

// File: tb/tb_add_to_acap_sim.sv
// Directed self-checking bench for add_to_acap_sim on a reduced ring (N=8, W=4, Q=4096).
module tb_add_to_acap_sim;

  localparam int RD   = 3;
  localparam int N    = 8;
  localparam int DW   = 32;
  localparam int W    = 4;
  localparam int KW   = 24;
  localparam int SA_W = 8;
  localparam int AI_W = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            write_enable_bram;
  logic [RD:0]     write_addr_input;
  logic [DW-1:0]   data_in;
  logic            load_a;
  logic [DW-1:0]   data_a;
  logic [AI_W-1:0] write_addr_a;
  logic            start_addToACAP;
  logic [DW*W-1:0] secret_key;
  logic [RD:0]     read_out;
  logic            done;
  logic [DW-1:0]   data_out;
  logic [SA_W-1:0] secret_addr;
  logic [SA_W-1:0] addr_d;

  logic [DW*W-1:0] key_rom [256];
  logic [SA_W-1:0] addr_log [$];
  longint          expAcc [16];
  int              assertCount = 0;
  int              failCount   = 0;
  int              cycles;

  add_to_acap_sim #(
    .RING_DEPTH(RD), .DATA_SIZE_ARB(DW), .Q(4096), .PE_NUMBER(2), .NTT_NUMBER(2),
    .LWE_SIZE(2), .D_R(2), .B_R(3), .A_WIDTH(2), .LOG_BG(4), .D_G(3)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .write_enable_bram (write_enable_bram),
    .write_addr_input  (write_addr_input),
    .data_in           (data_in),
    .load_a            (load_a),
    .data_a            (data_a),
    .write_addr_a      (write_addr_a),
    .start_addToACAP   (start_addToACAP),
    .secret_key        (secret_key),
    .read_out          (read_out),
    .done              (done),
    .data_out          (data_out),
    .secret_addr       (secret_addr)
  );

  // Key ROM: one address delay stage plus a registered read gives two cycles of latency.
  ShiftReg #(.SHIFT(1), .DATA(SA_W)) u_rom_addr_dly (
    .clk      (clk),
    .resetn   (resetn),
    .data_in  (secret_addr),
    .data_out (addr_d)
  );

  always @(posedge clk) secret_key <= key_rom[addr_d];

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic writeAcc(input int addr, input int value);
    write_enable_bram = 1'b1;
    write_addr_input  = (RD+1)'(addr);
    data_in           = DW'(value);
    @(negedge clk);
    write_enable_bram = 1'b0;
  endtask

  task automatic writeA(input int idx, input int value);
    load_a       = 1'b1;
    write_addr_a = AI_W'(idx);
    data_a       = DW'(value);
    @(negedge clk);
    load_a = 1'b0;
  endtask

  // mode 0: zero key, 1: gadget identity, 2: gadget identity times X on column 0
  task automatic loadKey(input int block, input int mode);
    logic [DW*W-1:0] word;
    int l, c, n;
    longint coef;
    for (int w = 0; w < KW; w++) begin
      word = '0;
      l = w / 4;
      c = (w / 2) % 2;
      for (int p = 0; p < W; p++) begin
        n = (w % 2) * 4 + p;
        coef = 0;
        if (mode == 1 && l / 3 == c && n == 0) coef = longint'(1) << (4 * (l % 3));
        if (mode == 2 && c == 0 && l < 3 && n == 1) coef = longint'(1) << (4 * l);
        if (mode == 2 && c == 1 && l >= 3 && n == 0) coef = longint'(1) << (4 * (l - 3));
        word[p*DW +: DW] = DW'(coef);
      end
      key_rom[block * KW + w] = word;
    end
  endtask

  task automatic readAll(input string phase);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      read_out = (RD+1)'(i);
      #1;
      checkOutput($sformatf("%s_acc[%0d]", phase, i), 64'(data_out), 64'(expAcc[i]));
    end
  endtask

  task automatic applyStimulus(input int budget, input bit poke, output int ncycles);
    logic [SA_W-1:0] prev;
    prev = secret_addr;
    addr_log.delete();
    start_addToACAP = 1'b1;
    @(negedge clk);
    start_addToACAP = 1'b0;
    ncycles = 1;
    while (done !== 1'b1 && ncycles < budget) begin
      if (secret_addr !== prev) begin
        addr_log.push_back(secret_addr);
        prev = secret_addr;
      end
      if (poke && ncycles == 3) begin
        write_enable_bram = 1'b1;
        write_addr_input  = '0;
        data_in           = 32'd999;
        load_a            = 1'b1;
        write_addr_a      = 2'd3;
        data_a            = 32'd1;
      end
      if (poke && ncycles == 4) begin
        write_enable_bram = 1'b0;
        load_a            = 1'b0;
      end
      @(negedge clk);
      ncycles++;
    end
    if (secret_addr !== prev) addr_log.push_back(secret_addr);
    checkOutput("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    resetn            = 1'b0;
    write_enable_bram = 1'b0;
    write_addr_input  = '0;
    data_in           = '0;
    load_a            = 1'b0;
    data_a            = '0;
    write_addr_a      = '0;
    start_addToACAP   = 1'b0;
    read_out          = '0;
    for (int i = 0; i < 256; i++) key_rom[i] = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_secret_addr", 64'(secret_addr), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] run 1: all a digits zero");
    loadKey(0, 1);
    for (int i = 0; i < 8; i++) begin
      writeAcc(i, 3000 + 10 * i);
      writeAcc(8 + i, 17 * i + 1);
      expAcc[i]     = 3000 + 10 * i;
      expAcc[8 + i] = 17 * i + 1;
    end
    for (int i = 0; i < 4; i++) writeA(i, 0);
    applyStimulus(50, 1'b0, cycles);
    checkOutput("run1_latency_within_7", 64'(cycles <= 7), 64'd1);
    checkOutput("run1_addr_changes", 64'(addr_log.size()), 64'd0);
    checkOutput("run1_secret_addr", 64'(secret_addr), 64'd0);
    readAll("run1");

    $display("[TB] run 2: a[0]=1 with gadget identity key");
    writeA(0, 1);
    applyStimulus(100, 1'b0, cycles);
    checkOutput("run2_secret_addr", 64'(secret_addr), 64'd23);
    for (int i = 0; i < 16; i++) expAcc[i] = (2 * expAcc[i]) % 4096;
    readAll("run2");

    $display("[TB] run 3: a[1]=2 with zero key, host writes while busy");
    writeA(0, 0);
    writeA(1, 2);
    applyStimulus(100, 1'b1, cycles);
    checkOutput("run3_addr_count", 64'(addr_log.size()), 64'd24);
    for (int i = 0; i < addr_log.size(); i++)
      checkOutput($sformatf("run3_addr[%0d]", i), 64'(addr_log[i]), 64'(72 + i));
    checkOutput("run3_secret_addr", 64'(secret_addr), 64'd95);
    readAll("run3");

    $display("[TB] run 4: gadget identity times X on column 0");
    loadKey(0, 2);
    writeA(0, 1);
    writeA(1, 0);
    for (int i = 0; i < 8; i++) begin
      writeAcc(i, (i == 0) ? 1 : ((i == 7) ? 5 : 0));
      writeAcc(8 + i, 100 * i);
      expAcc[i]     = 0;
      expAcc[8 + i] = 200 * i;
    end
    expAcc[0] = 4092;
    expAcc[1] = 1;
    expAcc[7] = 5;
    applyStimulus(100, 1'b0, cycles);
    readAll("run4");

    $display("[TB] run 5: reset during key fetch, then a clean run");
    loadKey(0, 1);
    start_addToACAP = 1'b1;
    @(negedge clk);
    start_addToACAP = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("mid_fetch_addr_nonzero", 64'(secret_addr != '0), 64'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_secret_addr", 64'(secret_addr), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      writeAcc(i, i + 1);
      writeAcc(8 + i, 4095 - i);
      expAcc[i]     = 2 * (i + 1);
      expAcc[8 + i] = 4094 - 2 * i;
    end
    applyStimulus(100, 1'b0, cycles);
    checkOutput("rerun_secret_addr", 64'(secret_addr), 64'd23);
    readAll("rerun");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
